shared_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing one datapath resource (a bus driven through an
//  AOI22-based AND-OR mux tree) between N requesters. Issues registered one-hot

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 35 +++
 rtl/shared_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_shared_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the round-robin bus arbiter: FSM encoding, size limits and
// a one-hot to binary index helper.
package arb_pkg;

   localparam int ARB_MAX_REQ = 16;
   localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_TURN  = 2'd2
   } arb_state_t;

   function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
      logic [ARB_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < ARB_MAX_REQ; i++) begin
         if (oh[i]) idx = idx | ARB_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping, found via a double-width mask and a lowest-set-bit isolate.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  win_oh,
   output logic [IW-1:0] win_idx,
   output logic          any
);

   logic [2*N-1:0]         dbl;
   logic [2*N-1:0]         mask;
   logic [2*N-1:0]         masked;
   logic [2*N-1:0]         lowest;
   logic [ARB_MAX_REQ-1:0] oh_ext;

   always_comb begin
      dbl    = {req, req};
      // Upper copy is never masked, so a wrapped winner is always found there.
      mask   = ~(((2*N)'(1) << ptr) - (2*N)'(1));
      masked = dbl & mask;
      lowest = masked & (~masked + (2*N)'(1));
      win_oh = lowest[N-1:0] | lowest[2*N-1:N];
      oh_ext = '0;
      oh_ext[N-1:0] = win_oh;
      win_idx = IW'(onehot_to_idx(oh_ext));
      any     = |req;
   end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter with registered one-hot grants and a one-cycle turnaround.
// Define ARB_TIMEOUT_EN to build the hold watchdog that revokes stuck grants.
module shared_bus_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         done,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] gnt_id,
   output logic                     busy,
   output logic                     timeout_err
);

   localparam int IW = $clog2(N_REQ);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]    id_q, id_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic             busy_q, busy_d;
   logic [N_REQ-1:0] win_oh;
   logic [IW-1:0]    win_idx;
   logic             any_req;
   logic             rel;
   logic             wdog_fire;

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .any     (any_req)
   );

   // A simultaneous done and req drop collapses into this single release.
   assign rel = (state_q == ARB_GRANT) && (done[id_q] || !req[id_q]);

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;

   assign wdog_fire = (state_q == ARB_GRANT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = (state_q == ARB_GRANT) ? cnt_q + CW'(1) : '0;
      tmo_d = wdog_fire && !rel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign timeout_err = tmo_q;
`else
   logic unused_cfg;
   assign unused_cfg  = ^TIMEOUT_CYCLES;
   assign wdog_fire   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      case (state_q)
         ARB_GRANT: begin
            if (rel || wdog_fire) begin
               state_d = ARB_TURN;
               gnt_d   = '0;
               busy_d  = 1'b0;
               ptr_d   = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
            end
         end
         default: begin
            // TURN already spent its dead cycle, so it arbitrates exactly like IDLE.
            if (any_req) begin
               state_d = ARB_GRANT;
               gnt_d   = win_oh;
               id_d    = win_idx;
               busy_d  = 1'b1;
            end else begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = id_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: ownership-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_shared_bus_arbiter;

   localparam int N   = 4;
   localparam int TMO = 8;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req  = '0;
   logic [N-1:0] done = '0;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         busy;
   logic         timeout_err;

   int n_checks = 0;
   int n_errs   = 0;

   shared_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .gnt         (gnt),
      .gnt_id      (gnt_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, where the next search starts.
   int m_owner;
   int m_last;
   int m_ptr;
   int m_hold;
   bit m_tmo;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_last  = 0;
         m_ptr   = 0;
         m_hold  = 0;
         m_tmo   = 1'b0;
      end else begin
         m_tmo = 1'b0;
         if (m_owner >= 0) begin
            if (done[m_owner] || !req[m_owner]) begin
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
            end else if (TMO_EN && m_hold >= TMO) begin
               m_tmo   = 1'b1;
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
            end else begin
               m_hold++;
            end
         end else begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (!found && req[c]) begin
                  found   = 1'b1;
                  m_owner = c;
                  m_last  = c;
                  m_hold  = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         logic [N-1:0] exp_gnt;
         exp_gnt = '0;
         if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
         chk("model_gnt", 32'(gnt), 32'(exp_gnt));
         chk("model_gnt_id", 32'(gnt_id), 32'(m_last));
         chk("model_busy", 32'(busy), 32'(m_owner >= 0));
         chk("model_timeout_err", 32'(timeout_err), 32'(m_tmo));
         chk("onehot0_gnt", 32'($onehot0(gnt)), 32'd1);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_grant(output int id, output int zeros);
      bit got;
      got   = 1'b0;
      id    = -1;
      zeros = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (gnt != '0) begin
            got = 1'b1;
            for (int b = 0; b < N; b++) if (gnt[b]) id = b;
         end else begin
            zeros++;
            @(negedge clk);
         end
      end
      if (!got) begin
         n_checks++;
         n_errs++;
         $display("FAIL wait_grant: no grant within 40 cycles, required a grant");
      end
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      req  = '0;
      done = '0;
      tick(2);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int id;
      int zeros;
      logic [1:0] exp_q[$];
      logic [1:0] e;

      rst_n = 1'b0;
      tick(1);
      chk("reset_gnt", 32'(gnt), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_gnt_id", 32'(gnt_id), 32'h0);
      chk("reset_timeout_err", 32'(timeout_err), 32'h0);
      tick(1);
      #1 rst_n = 1'b1;

      // Grant latency and lowest index from pointer 0.
      req = 4'b0101;
      tick(1);
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_gnt_id", 32'(gnt_id), 32'h0);
      chk("t1_busy", 32'(busy), 32'h1);

      // done release, single dead cycle, next owner after pointer.
      done = 4'b0001;
      tick(1);
      chk("t2_dead_gnt", 32'(gnt), 32'h0);
      chk("t2_dead_busy", 32'(busy), 32'h0);
      chk("t2_dead_gnt_id", 32'(gnt_id), 32'h0);
      done = '0;
      req  = 4'b0100;
      tick(1);
      chk("t2_gnt", 32'(gnt), 32'h4);
      chk("t2_gnt_id", 32'(gnt_id), 32'h2);
      done = 4'b1011;
      tick(1);
      chk("t2_nonowner_done", 32'(gnt), 32'h4);
      done = '0;
      req  = '0;
      tick(2);

      // Pointer is 3: wrap behaviour and lone re-request.
      req = 4'b1001;
      wait_grant(id, zeros);
      chk("t4_first_id", 32'(id), 32'd3);
      chk("t4_first_gnt", 32'(gnt), 32'h8);
      req = 4'b0001;
      tick(1);
      wait_grant(id, zeros);
      chk("t4_wrap_id", 32'(id), 32'd0);
      chk("t4_wrap_dead", 32'(zeros), 32'd1);
      req = '0;
      tick(2);
      req = 4'b1000;
      wait_grant(id, zeros);
      chk("t4_lone_id", 32'(id), 32'd3);
      done = 4'b1000;
      tick(1);
      done = '0;
      wait_grant(id, zeros);
      chk("t4_regrant_id", 32'(id), 32'd3);
      chk("t4_regrant_dead", 32'(zeros), 32'd1);
      req = '0;
      tick(2);

      // Fair rotation with all requesters held.
      do_reset();
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant(id, zeros);
         e = exp_q.pop_front();
         chk("t3_rr_order", 32'(id), 32'(e));
         if (k > 0) chk("t3_dead_cycles", 32'(zeros), 32'd1);
         tick(2);
         done = '0;
         if (id >= 0) done[id] = 1'b1;
         tick(1);
         done = '0;
      end
      req = '0;
      tick(2);

      // Async reset mid-grant clears outputs and the pointer.
      req = 4'b0010;
      wait_grant(id, zeros);
      req = '0;
      tick(2);
      req = 4'b0100;
      wait_grant(id, zeros);
      chk("t5_pre_id", 32'(id), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_gnt", 32'(gnt), 32'h0);
      chk("t5_async_busy", 32'(busy), 32'h0);
      chk("t5_async_gnt_id", 32'(gnt_id), 32'h0);
      req = '0;
      tick(2);
      #1 rst_n = 1'b1;
      req = 4'b0110;
      wait_grant(id, zeros);
      chk("t5_post_gnt", 32'(gnt), 32'h2);
      req = '0;
      tick(2);

      // Owner that never releases.
      req = 4'b0001;
      wait_grant(id, zeros);
`ifdef ARB_TIMEOUT_EN
      tick(TMO - 1);
      chk("t6_last_held", 32'(gnt), 32'h1);
      tick(1);
      chk("t6_revoked_gnt", 32'(gnt), 32'h0);
      chk("t6_timeout_err", 32'(timeout_err), 32'h1);
      tick(1);
      chk("t6_regrant_gnt", 32'(gnt), 32'h1);
      chk("t6_err_pulse_end", 32'(timeout_err), 32'h0);
`else
      tick(110);
      chk("t6_held_gnt", 32'(gnt), 32'h1);
      chk("t6_no_timeout", 32'(timeout_err), 32'h0);
`endif
      req = '0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
